// File: rtl/tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its surroundings.
//   master : scheduler side (samples start/abort/tile_done, drives tile op fields and status)
//   slave  : host / systolic-array side
// Widths are derived from MATRIX_DIM and TILE_DIM exactly as inside tile_scheduler.
interface tile_scheduler_if #(
    parameter int unsigned MATRIX_DIM = 32,
    parameter int unsigned TILE_DIM   = 4
);
    localparam int unsigned NT         = MATRIX_DIM / TILE_DIM;
    localparam int unsigned IdxW       = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned ADDR_WIDTH = $clog2(MATRIX_DIM * MATRIX_DIM);
    localparam int unsigned CntW       = $clog2(NT * NT * NT + 1);

    logic                  start;
    logic                  abort;
    logic                  tile_done;
    logic                  tile_start;
    logic                  acc_clear;
    logic [IdxW-1:0]       i_idx;
    logic [IdxW-1:0]       j_idx;
    logic [IdxW-1:0]       k_idx;
    logic [ADDR_WIDTH-1:0] a_base;
    logic [ADDR_WIDTH-1:0] b_base;
    logic [ADDR_WIDTH-1:0] c_base;
    logic [CntW-1:0]       tile_count;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, abort, tile_done,
        output tile_start, acc_clear, i_idx, j_idx, k_idx,
               a_base, b_base, c_base, tile_count, busy, done
    );

    modport slave (
        output start, abort, tile_done,
        input  tile_start, acc_clear, i_idx, j_idx, k_idx,
               a_base, b_base, c_base, tile_count, busy, done
    );
endinterface

// File: rtl/tile_scheduler.sv
// Tile scheduler for the tiled matrix-multiply engine.
// Walks every (i, j, k) tile triple (k innermost), issuing one tile op per triple and
// waiting for the array's tile_done before moving on; pulses done after the last tile.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tile_scheduler_if.master (start/abort/tile_done in; tile op fields and status out)
module tile_scheduler #(
    parameter int unsigned MATRIX_DIM = 32,
    parameter int unsigned TILE_DIM   = 4
) (
    input logic              clk,
    input logic              rst_n,
    tile_scheduler_if.master bus
);
    localparam int unsigned NT         = MATRIX_DIM / TILE_DIM;
    localparam int unsigned IdxW       = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned ADDR_WIDTH = $clog2(MATRIX_DIM * MATRIX_DIM);
    localparam int unsigned CntW       = $clog2(NT * NT * NT + 1);

    localparam logic [IdxW-1:0]       IdxMax    = IdxW'(NT - 1);
    // Row stride truncates harmlessly when NT=1: the index it multiplies is always 0.
    localparam logic [ADDR_WIDTH-1:0] RowStride = ADDR_WIDTH'(TILE_DIM * MATRIX_DIM);
    localparam logic [ADDR_WIDTH-1:0] ColStride = ADDR_WIDTH'(TILE_DIM);

    if (MATRIX_DIM % TILE_DIM != 0) begin : g_bad_cfg
        $error("tile_scheduler: MATRIX_DIM must be a multiple of TILE_DIM");
    end

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StAdvance, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_tile;

    assign last_tile = (i_q == IdxMax) && (j_q == IdxMax) && (k_q == IdxMax);

    // State and loop registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and loop-nest stepping.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle:    if (bus.start) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait:    if (bus.tile_done) state_d = last_tile ? StDone : StAdvance;
            StAdvance: state_d = StIssue;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (state_q == StIdle) begin
            // start beats a coincident abort here
            if (bus.start) begin
                i_d   = '0;
                j_d   = '0;
                k_d   = '0;
                cnt_d = '0;
            end
        end else if (bus.abort) begin
            // abort freezes indices and count, just drops back to idle
            state_d = StIdle;
        end else begin
            if (state_q == StWait && bus.tile_done) cnt_d = cnt_q + 1'b1;
            if (state_q == StAdvance) begin
                k_d = (k_q == IdxMax) ? '0 : k_q + 1'b1;
                if (k_q == IdxMax) begin
                    j_d = (j_q == IdxMax) ? '0 : j_q + 1'b1;
                    if (j_q == IdxMax) i_d = (i_q == IdxMax) ? '0 : i_q + 1'b1;
                end
            end
        end
    end

    // Outputs: status decoded from state, addresses straight from the index registers.
    always_comb begin
        bus.tile_start = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            StIssue: begin
                bus.tile_start = 1'b1;
                bus.busy       = 1'b1;
            end
            StWait, StAdvance: bus.busy = 1'b1;
            StDone:            bus.done = 1'b1;
            default: ;
        endcase

        bus.i_idx      = i_q;
        bus.j_idx      = j_q;
        bus.k_idx      = k_q;
        bus.tile_count = cnt_q;
        bus.acc_clear  = (k_q == '0);
        bus.a_base     = ADDR_WIDTH'(i_q) * RowStride + ADDR_WIDTH'(k_q) * ColStride;
        bus.b_base     = ADDR_WIDTH'(k_q) * RowStride + ADDR_WIDTH'(j_q) * ColStride;
        bus.c_base     = ADDR_WIDTH'(i_q) * RowStride + ADDR_WIDTH'(j_q) * ColStride;
    end
endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: an 8x8 / 4x4 instance (2x2x2 tiles) and a
// 4x4 / 4x4 instance (single tile). Expected values are hand-computed tables.
module tb_tile_scheduler;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;
    int   cyc;

    tile_scheduler_if #(.MATRIX_DIM(8), .TILE_DIM(4)) bus ();
    tile_scheduler_if #(.MATRIX_DIM(4), .TILE_DIM(4)) bus1 ();

    tile_scheduler #(.MATRIX_DIM(8), .TILE_DIM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    tile_scheduler #(.MATRIX_DIM(4), .TILE_DIM(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ops in (i,j,k) order 000..111 for the 8x8 matrix with 4x4 tiles.
    logic [5:0] exp_a   [8];
    logic [5:0] exp_b   [8];
    logic [5:0] exp_c   [8];
    logic       exp_clr [8];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tile_start !== 1'b0 ||
            bus.tile_count !== 4'd0) begin
            errs++;
            $display("FAIL reset_status: busy=%b done=%b tile_start=%b count=%0d, want 0 0 0 0",
                     bus.busy, bus.done, bus.tile_start, bus.tile_count);
        end
        vecs++;
        if (bus.a_base !== 6'd0 || bus.b_base !== 6'd0 || bus.c_base !== 6'd0 ||
            bus.acc_clear !== 1'b1 || {bus.i_idx, bus.j_idx, bus.k_idx} !== 3'd0) begin
            errs++;
            $display("FAIL reset_addr: a=%0d b=%0d c=%0d clr=%b ijk=%b%b%b, want 0 0 0 1 000",
                     bus.a_base, bus.b_base, bus.c_base, bus.acc_clear,
                     bus.i_idx, bus.j_idx, bus.k_idx);
        end
    endtask

    // Full run. rand_w: random 1..20 wait per op; noise: stray tile_done in ISSUE/ADVANCE
    // and stray start while busy and in the DONE cycle.
    task automatic test_sequence(input bit rand_w, input bit noise);
        int w;
        int sum_w;
        sum_w = 0;
        cyc = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int op = 0; op < 8; op++) begin
            w = rand_w ? int'($urandom_range(20, 1)) : 1;
            sum_w += w;
            vecs++;
            if (bus.tile_start !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errs++;
                $display("FAIL issue_ctl op%0d: tile_start=%b busy=%b done=%b, want 1 1 0",
                         op, bus.tile_start, bus.busy, bus.done);
            end
            vecs++;
            if (bus.a_base !== exp_a[op] || bus.b_base !== exp_b[op] ||
                bus.c_base !== exp_c[op] || bus.acc_clear !== exp_clr[op]) begin
                errs++;
                $display("FAIL issue_addr op%0d: a=%0d b=%0d c=%0d clr=%b, want %0d %0d %0d %b",
                         op, bus.a_base, bus.b_base, bus.c_base, bus.acc_clear,
                         exp_a[op], exp_b[op], exp_c[op], exp_clr[op]);
            end
            vecs++;
            if ({bus.i_idx, bus.j_idx, bus.k_idx} !== 3'(op) || bus.tile_count !== 4'(op)) begin
                errs++;
                $display("FAIL issue_idx op%0d: ijk=%b%b%b count=%0d, want %b count %0d",
                         op, bus.i_idx, bus.j_idx, bus.k_idx, bus.tile_count, 3'(op), op);
            end
            if (noise) bus.tile_done = 1'b1;
            step();
            bus.tile_done = 1'b0;
            for (int c = 1; c <= w; c++) begin
                vecs++;
                if (bus.tile_start !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                    bus.a_base !== exp_a[op] || bus.b_base !== exp_b[op] ||
                    bus.c_base !== exp_c[op] || bus.tile_count !== 4'(op)) begin
                    errs++;
                    $display("FAIL wait op%0d c%0d: ts=%b busy=%b done=%b a=%0d b=%0d c=%0d n=%0d, want 0 1 0 %0d %0d %0d %0d",
                             op, c, bus.tile_start, bus.busy, bus.done, bus.a_base,
                             bus.b_base, bus.c_base, bus.tile_count,
                             exp_a[op], exp_b[op], exp_c[op], op);
                end
                bus.tile_done = (c == w);
                if (noise && c == 1) bus.start = 1'b1;
                step();
                bus.tile_done = 1'b0;
                bus.start = 1'b0;
            end
            if (op < 7) begin
                vecs++;
                if (bus.tile_start !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                    bus.tile_count !== 4'(op + 1)) begin
                    errs++;
                    $display("FAIL advance op%0d: ts=%b busy=%b done=%b count=%0d, want 0 1 0 %0d",
                             op, bus.tile_start, bus.busy, bus.done, bus.tile_count, op + 1);
                end
                if (noise) bus.tile_done = 1'b1;
                step();
                bus.tile_done = 1'b0;
            end
        end
        vecs++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || cyc != sum_w + 16 ||
            bus.tile_count !== 4'd8) begin
            errs++;
            $display("FAIL done_pulse: done=%b busy=%b cycle=%0d count=%0d, want 1 0 %0d 8",
                     bus.done, bus.busy, cyc, bus.tile_count, sum_w + 16);
        end
        if (noise) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vecs++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tile_start !== 1'b0 ||
                bus.tile_count !== 4'd8 || {bus.i_idx, bus.j_idx, bus.k_idx} !== 3'b111 ||
                bus.c_base !== 6'd36) begin
                errs++;
                $display("FAIL post_done c%0d: done=%b busy=%b ts=%b count=%0d ijk=%b%b%b cb=%0d, want 0 0 0 8 111 36",
                         c, bus.done, bus.busy, bus.tile_start, bus.tile_count,
                         bus.i_idx, bus.j_idx, bus.k_idx, bus.c_base);
            end
            step();
        end
    endtask

    task automatic test_abort();
        // abort together with start in idle: start wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        vecs++;
        if (bus.tile_start !== 1'b1 || bus.tile_count !== 4'd0) begin
            errs++;
            $display("FAIL start_over_abort: tile_start=%b count=%0d, want 1 0",
                     bus.tile_start, bus.tile_count);
        end
        for (int op = 0; op < 3; op++) begin
            step();
            bus.tile_done = 1'b1;
            step();
            bus.tile_done = 1'b0;
            step();
        end
        vecs++;
        if (bus.tile_start !== 1'b1 || {bus.i_idx, bus.j_idx, bus.k_idx} !== 3'b011) begin
            errs++;
            $display("FAIL abort_reach_op3: tile_start=%b ijk=%b%b%b, want 1 011",
                     bus.tile_start, bus.i_idx, bus.j_idx, bus.k_idx);
        end
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tile_start !== 1'b0 ||
            bus.tile_count !== 4'd3) begin
            errs++;
            $display("FAIL abort_idle: busy=%b done=%b ts=%b count=%0d, want 0 0 0 3",
                     bus.busy, bus.done, bus.tile_start, bus.tile_count);
        end
        bus.tile_done = 1'b1;
        step();
        bus.tile_done = 1'b0;
        step();
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tile_start !== 1'b0 ||
            bus.tile_count !== 4'd3) begin
            errs++;
            $display("FAIL abort_stays_idle: busy=%b done=%b ts=%b count=%0d, want 0 0 0 3",
                     bus.busy, bus.done, bus.tile_start, bus.tile_count);
        end
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.tile_done = 1'b1;
        step();
        bus.tile_done = 1'b0;
        step();
        step();
        // now in WAIT of op1 with count 1
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.tile_start !== 1'b0 || bus.done !== 1'b0 ||
            bus.tile_count !== 4'd0 || bus.acc_clear !== 1'b1 || bus.a_base !== 6'd0 ||
            bus.b_base !== 6'd0 || bus.c_base !== 6'd0) begin
            errs++;
            $display("FAIL async_reset: busy=%b ts=%b done=%b count=%0d clr=%b a=%0d b=%0d c=%0d, want 0 0 0 0 1 0 0 0",
                     bus.busy, bus.tile_start, bus.done, bus.tile_count, bus.acc_clear,
                     bus.a_base, bus.b_base, bus.c_base);
        end
        step();
        rst_n = 1'b1;
        bus.tile_done = 1'b1;
        step();
        bus.tile_done = 1'b0;
        step();
        vecs++;
        if (bus.busy !== 1'b0 || bus.tile_start !== 1'b0 || bus.tile_count !== 4'd0 ||
            {bus.i_idx, bus.j_idx, bus.k_idx} !== 3'd0) begin
            errs++;
            $display("FAIL reset_then_tile_done: busy=%b ts=%b count=%0d ijk=%b%b%b, want 0 0 0 000",
                     bus.busy, bus.tile_start, bus.tile_count, bus.i_idx, bus.j_idx, bus.k_idx);
        end
    endtask

    // Single-tile configuration: ISSUE in cycle 1, WAIT in cycle 2, done in cycle 3.
    task automatic test_single_tile();
        cyc = 0;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        vecs++;
        if (bus1.tile_start !== 1'b1 || bus1.busy !== 1'b1 || bus1.acc_clear !== 1'b1 ||
            bus1.a_base !== 4'd0 || bus1.b_base !== 4'd0 || bus1.c_base !== 4'd0) begin
            errs++;
            $display("FAIL nt1_issue: ts=%b busy=%b clr=%b a=%0d b=%0d c=%0d, want 1 1 1 0 0 0",
                     bus1.tile_start, bus1.busy, bus1.acc_clear,
                     bus1.a_base, bus1.b_base, bus1.c_base);
        end
        step();
        bus1.tile_done = 1'b1;
        step();
        bus1.tile_done = 1'b0;
        vecs++;
        if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.tile_count !== 1'b1 || cyc != 3) begin
            errs++;
            $display("FAIL nt1_done: done=%b busy=%b count=%0d cycle=%0d, want 1 0 1 3",
                     bus1.done, bus1.busy, bus1.tile_count, cyc);
        end
        step();
        vecs++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
            errs++;
            $display("FAIL nt1_idle: done=%b busy=%b, want 0 0", bus1.done, bus1.busy);
        end
    endtask

    initial begin
        exp_a[0] = 6'd0;  exp_b[0] = 6'd0;  exp_c[0] = 6'd0;  exp_clr[0] = 1'b1;
        exp_a[1] = 6'd4;  exp_b[1] = 6'd32; exp_c[1] = 6'd0;  exp_clr[1] = 1'b0;
        exp_a[2] = 6'd0;  exp_b[2] = 6'd4;  exp_c[2] = 6'd4;  exp_clr[2] = 1'b1;
        exp_a[3] = 6'd4;  exp_b[3] = 6'd36; exp_c[3] = 6'd4;  exp_clr[3] = 1'b0;
        exp_a[4] = 6'd32; exp_b[4] = 6'd0;  exp_c[4] = 6'd32; exp_clr[4] = 1'b1;
        exp_a[5] = 6'd36; exp_b[5] = 6'd32; exp_c[5] = 6'd32; exp_clr[5] = 1'b0;
        exp_a[6] = 6'd32; exp_b[6] = 6'd4;  exp_c[6] = 6'd36; exp_clr[6] = 1'b1;
        exp_a[7] = 6'd36; exp_b[7] = 6'd36; exp_c[7] = 6'd36; exp_clr[7] = 1'b0;

        vecs = 0;
        errs = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.tile_done = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus1.tile_done = 1'b0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();

        test_sequence(1'b0, 1'b0);   // W=1 everywhere, done in cycle 24
        test_sequence(1'b1, 1'b1);   // random waits plus stray start/tile_done
        test_sequence(1'b0, 1'b0);   // fresh start restarts from op0, count 0
        test_abort();
        test_async_reset();
        test_single_tile();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
